dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the core load/store unit (port C) and a DMA/debug engine (port D). Each cycle it selects at most one requester, drives the memory's write enable, address and write data, and returns registered read data one cycle later. It sits between the datapath's memory stage and the data memory. It provides round-robin fairness plus a bounded DMA lock for short bursts.

---
 rtl/dmem_arbiter_if.sv | 62 ++++++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters (core LSU "c", DMA/debug "d"),
// the arbiter and the single-port data memory. Error flags exist only with DMEM_ARB_ERRCHK_EN.
interface dmem_arbiter_if;
   logic        c_req;
   logic        c_we;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic        c_gnt;
   logic        c_rvalid;
   logic [31:0] c_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_lock;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

`ifdef DMEM_ARB_ERRCHK_EN
   logic        c_err;
   logic        d_err;

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      output d_req, d_we, d_addr, d_wdata, d_lock,
      input  c_gnt, c_rvalid, c_rdata, c_err,
      input  d_gnt, d_rvalid, d_rdata, d_err
   );

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      input  d_req, d_we, d_addr, d_wdata, d_lock,
      output c_gnt, c_rvalid, c_rdata, c_err,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
`else
   modport master (
      output c_req, c_we, c_addr, c_wdata,
      output d_req, d_we, d_addr, d_wdata, d_lock,
      input  c_gnt, c_rvalid, c_rdata,
      input  d_gnt, d_rvalid, d_rdata
   );

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      input  d_req, d_we, d_addr, d_wdata, d_lock,
      output c_gnt, c_rvalid, c_rdata,
      output d_gnt, d_rvalid, d_rdata,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared data memory with a bounded DMA lock.
// Define DMEM_ARB_ERRCHK_EN to add misaligned/out-of-range access checking (c_err/d_err).
module dmem_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave bus
);

   localparam logic [3:0] HOLD_CAP = 4'(MAX_HOLD);

   typedef enum logic {
      FREE     = 1'b0,
      LOCKED_D = 1'b1
   } lock_state_t;

   lock_state_t state_reg;
   logic        last_reg;        // 0: C granted last, 1: D granted last
   logic [3:0]  hcnt_reg;

   logic        c_rvalid_reg;
   logic        d_rvalid_reg;
   logic [31:0] c_rdata_reg;
   logic [31:0] d_rdata_reg;

   logic        c_win;
   logic        d_win;
   logic        c_gnt;
   logic        d_gnt;
   logic [1:0]  bad;             // [0]: C access illegal, [1]: D access illegal

`ifdef DMEM_ARB_ERRCHK_EN
   logic [31:0] port_addr [2];
   logic        c_err_reg;
   logic        d_err_reg;

   assign port_addr[0] = bus.c_addr;
   assign port_addr[1] = bus.d_addr;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chk
         assign bad[gi] = (port_addr[gi][1:0] != 2'b00) || (port_addr[gi][31:8] != 24'd0);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c_err_reg <= 1'b0;
         d_err_reg <= 1'b0;
      end else begin
         c_err_reg <= c_gnt & bad[0];
         d_err_reg <= d_gnt & bad[1];
      end
   end

   assign bus.c_err = c_err_reg & rst_n;
   assign bus.d_err = d_err_reg & rst_n;
`else
   assign bad = 2'b00;
`endif

   // Arbitration decision; reset gating is applied afterwards so no grant leaks during reset.
   always_comb begin
      c_win = 1'b0;
      d_win = 1'b0;
      if (state_reg == LOCKED_D) begin
         if (bus.d_req && (!bus.c_req || (hcnt_reg < HOLD_CAP)))
            d_win = 1'b1;
         else if (bus.c_req)
            c_win = 1'b1;
      end else begin
         if (bus.c_req && bus.d_req) begin
            c_win = last_reg;
            d_win = ~last_reg;
         end else begin
            c_win = bus.c_req;
            d_win = bus.d_req;
         end
      end
   end

   assign c_gnt = c_win & rst_n;
   assign d_gnt = d_win & rst_n;
   assign bus.c_gnt = c_gnt;
   assign bus.d_gnt = d_gnt;

   always_comb begin
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (c_gnt) begin
         bus.mem_we    = bus.c_we & ~bad[0];
         bus.mem_addr  = bus.c_addr;
         bus.mem_wdata = bus.c_wdata;
      end else if (d_gnt) begin
         bus.mem_we    = bus.d_we & ~bad[1];
         bus.mem_addr  = bus.d_addr;
         bus.mem_wdata = bus.d_wdata;
      end
   end

   // Lock FSM, round-robin pointer and read-return registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= FREE;
         hcnt_reg     <= 4'd0;
         last_reg     <= 1'b1;
         c_rvalid_reg <= 1'b0;
         d_rvalid_reg <= 1'b0;
         c_rdata_reg  <= '0;
         d_rdata_reg  <= '0;
      end else begin
         c_rvalid_reg <= c_gnt & ~bus.c_we;
         d_rvalid_reg <= d_gnt & ~bus.d_we;
         if (c_gnt && !bus.c_we)
            c_rdata_reg <= bad[0] ? 32'd0 : bus.mem_rdata;
         if (d_gnt && !bus.d_we)
            d_rdata_reg <= bad[1] ? 32'd0 : bus.mem_rdata;

         if (c_gnt)
            last_reg <= 1'b0;
         else if (d_gnt)
            last_reg <= 1'b1;

         case (state_reg)
            FREE: begin
               if (d_gnt && bus.d_lock) begin
                  state_reg <= LOCKED_D;
                  hcnt_reg  <= 4'd1;
               end
            end
            LOCKED_D: begin
               if (d_gnt) begin
                  if (!bus.d_lock) begin
                     state_reg <= FREE;
                     hcnt_reg  <= 4'd0;
                  end else if (bus.c_req && (hcnt_reg != 4'd15)) begin
                     hcnt_reg <= hcnt_reg + 4'd1;
                  end
               end else begin
                  // D idle or capped: C takes over and the lock ends.
                  state_reg <= FREE;
                  hcnt_reg  <= 4'd0;
               end
            end
            default: begin
               state_reg <= FREE;
               hcnt_reg  <= 4'd0;
            end
         endcase
      end
   end

   // Returns in flight when reset arrives are dropped rather than presented.
   assign bus.c_rvalid = c_rvalid_reg & rst_n;
   assign bus.d_rvalid = d_rvalid_reg & rst_n;
   assign bus.c_rdata  = c_rdata_reg;
   assign bus.d_rdata  = d_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grants and memory drive checked per cycle,
// read returns checked by a separate monitor against a queue of expected data.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.MAX_HOLD(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory model: unwritten word i reads as 0x1000_0000 | i.
   logic [31:0] mem [64];
   bit   [63:0] wr_mask;
   always @(posedge clk) begin
      if (bus.mem_we) begin
         mem[bus.mem_addr[7:2]]     <= bus.mem_wdata;
         wr_mask[bus.mem_addr[7:2]] <= 1'b1;
      end
   end
   assign bus.mem_rdata = wr_mask[bus.mem_addr[7:2]] ? mem[bus.mem_addr[7:2]]
                                                    : (32'h1000_0000 | 32'(bus.mem_addr[7:2]));

   int checks = 0;
   int failures = 0;
   logic [31:0] c_q [$];
   logic [31:0] d_q [$];

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_c(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata;
   endtask

   task automatic set_d(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic lock);
      bus.d_req = req; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_lock = lock;
   endtask

   // One bus cycle: check grants and write enable mid-cycle, queue the expected read return.
   task automatic cycle(input string name, input logic egc, input logic egd, input logic ewe,
                        input logic [31:0] exp_rd);
      @(negedge clk);
      check1({name, " c_gnt"}, 32'(bus.c_gnt), 32'(egc));
      check1({name, " d_gnt"}, 32'(bus.d_gnt), 32'(egd));
      check1({name, " mem_we"}, 32'(bus.mem_we), 32'(ewe));
      $display("cycle %-12s c_gnt=%0b d_gnt=%0b mem_we=%0b addr=%h", name, bus.c_gnt, bus.d_gnt,
               bus.mem_we, bus.mem_addr);
      if (egc && !bus.c_we) c_q.push_back(exp_rd);
      if (egd && !bus.d_we) d_q.push_back(exp_rd);
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (bus.c_rvalid) begin
            if (c_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL c_rvalid unexpected: got 1 expected 0");
            end else begin
               check1("c_rdata", bus.c_rdata, c_q.pop_front());
            end
         end
         if (bus.d_rvalid) begin
            if (d_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL d_rvalid unexpected: got 1 expected 0");
            end else begin
               check1("d_rdata", bus.d_rdata, d_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      set_c(1'b1, 1'b0, 32'h20, 32'h0);
      set_d(1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
      rst_n = 1'b0;

      // Reset held with both requesting
      for (int i = 0; i < 3; i++) cycle("reset", 1'b0, 1'b0, 1'b0, 32'h0);
      check1("rst c_rvalid", 32'(bus.c_rvalid), 32'h0);
      check1("rst d_rvalid", 32'(bus.d_rvalid), 32'h0);
      check1("rst c_rdata", bus.c_rdata, 32'h0);
      check1("rst d_rdata", bus.d_rdata, 32'h0);
      rst_n = 1'b1;

      // First contended cycle goes to C, then strict alternation
      for (int i = 0; i < 7; i++) begin
         if (i % 2 == 0) cycle("rr C", 1'b1, 1'b0, 1'b0, 32'h1000_0008);
         else            cycle("rr D", 1'b0, 1'b1, 1'b0, 32'h1000_0009);
      end

      // Write/read round trip on C
      set_d(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      set_c(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
      cycle("c wr 10", 1'b1, 1'b0, 1'b1, 32'h0);
      set_c(1'b1, 1'b0, 32'h10, 32'h0);
      cycle("c rd 10", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);

      // D write then C read of the same word next cycle
      set_c(1'b0, 1'b0, 32'h0, 32'h0);
      set_d(1'b1, 1'b1, 32'h14, 32'h1234_5678, 1'b0);
      cycle("d wr 14", 1'b0, 1'b1, 1'b1, 32'h0);
      set_d(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      set_c(1'b1, 1'b0, 32'h14, 32'h0);
      cycle("c rd 14", 1'b1, 1'b0, 1'b0, 32'h1234_5678);

      // Lock cap: four D grants, then C, then D by round robin
      set_c(1'b1, 1'b0, 32'h20, 32'h0);
      set_d(1'b1, 1'b0, 32'h24, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) cycle("lock D", 1'b0, 1'b1, 1'b0, 32'h1000_0009);
      cycle("cap C", 1'b1, 1'b0, 1'b0, 32'h1000_0008);
      set_d(1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
      cycle("post D", 1'b0, 1'b1, 1'b0, 32'h1000_0009);
      set_c(1'b0, 1'b0, 32'h0, 32'h0);
      set_d(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      cycle("idle", 1'b0, 1'b0, 1'b0, 32'h0);

      // Reset in the middle of a locked burst with a read return pending
      set_d(1'b1, 1'b0, 32'h24, 32'h0, 1'b1);
      cycle("burst D", 1'b0, 1'b1, 1'b0, 32'h1000_0009);
      rst_n = 1'b0;
      c_q.delete();
      d_q.delete();
      set_d(1'b1, 1'b1, 32'h2C, 32'hBAD0_BAD0, 1'b1);
      set_c(1'b1, 1'b0, 32'h20, 32'h0);
      cycle("mid rst", 1'b0, 1'b0, 1'b0, 32'h0);
      check1("mid rst d_rvalid", 32'(bus.d_rvalid), 32'h0);
      rst_n = 1'b1;
      set_d(1'b1, 1'b1, 32'h28, 32'hCAFE_F00D, 1'b1);
      cycle("free C", 1'b1, 1'b0, 1'b0, 32'h1000_0008);
      set_c(1'b0, 1'b0, 32'h0, 32'h0);
      cycle("d wr 28", 1'b0, 1'b1, 1'b1, 32'h0);
      set_d(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      set_c(1'b1, 1'b0, 32'h2C, 32'h0);
      cycle("c rd 2C", 1'b1, 1'b0, 1'b0, 32'h1000_000B);
      set_c(1'b1, 1'b0, 32'h28, 32'h0);
      cycle("c rd 28", 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);

`ifdef DMEM_ARB_ERRCHK_EN
      // Illegal accesses are granted but never write; err pulses one cycle later
      set_c(1'b1, 1'b1, 32'h102, 32'h55AA_55AA);
      cycle("c wr 102", 1'b1, 1'b0, 1'b0, 32'h0);
      check1("c_err wr 102", 32'(bus.c_err), 32'h1);
      check1("d_err wr 102", 32'(bus.d_err), 32'h0);
      set_c(1'b1, 1'b0, 32'h0, 32'h0);
      cycle("c rd 0", 1'b1, 1'b0, 1'b0, 32'h1000_0000);
      check1("c_err rd 0", 32'(bus.c_err), 32'h0);
      set_c(1'b1, 1'b0, 32'h104, 32'h0);
      cycle("c rd 104", 1'b1, 1'b0, 1'b0, 32'h0);
      check1("c_err rd 104", 32'(bus.c_err), 32'h1);
      set_c(1'b0, 1'b0, 32'h0, 32'h0);
      set_d(1'b1, 1'b1, 32'h31, 32'h7777_7777, 1'b0);
      cycle("d wr 31", 1'b0, 1'b1, 1'b0, 32'h0);
      check1("d_err wr 31", 32'(bus.d_err), 32'h1);
      set_d(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
`endif

      set_c(1'b0, 1'b0, 32'h0, 32'h0);
      set_d(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      cycle("drain", 1'b0, 1'b0, 1'b0, 32'h0);
      cycle("drain", 1'b0, 1'b0, 1'b0, 32'h0);
      check1("c returns outstanding", 32'(c_q.size()), 32'h0);
      check1("d returns outstanding", 32'(d_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
